key_display_buffer: RTL
=======================

// Module: key_display_buffer
// PURPOSE
//  Scrolling N-digit letter display for the Enigma front panel. Sits between the
//  PS2 key decoder (key_rdy level + letter code) and the HEX0..HEX(N-1) displays.
//  Captures one code per key press with auto-repeat suppression and shifts letters
//  in from the right. Also handles backspace/clear and drives 7-seg patterns directly.
// PARAMETERS
//  NUM_DIGITS      6         number of 7-seg digits held/driven (>=2)
//  SEG_ACTIVE_LOW  1         1: segment on = 0 (blank = 7'h7F); 0: on = 1 (blank = 7'h00)
//  BLINK_CYCLES    25000000  half-period of full-buffer blink (DISPLAY_BLINK_EN only)
// PORTS
//  clk       in   1              system clock (CLOCK_50 at top level)
//  rst       in   1              synchronous, active-high reset
//  key_rdy   in   1              level from PS2 decoder; high while code valid/held
//  key_code  in   5              0-25 = A-Z, 26 = space, 27 = backspace, 28 = clear, 29-31 invalid
//  seg_out   out  7*NUM_DIGITS   digit i at [7i+6:7i], bit order gfedcba; digit 0 = rightmost/newest
//  count     out  CW             letters held, CW = $clog2(NUM_DIGITS+1)
//  full      out  1              count == NUM_DIGITS
//  overflow  out  1              1-cycle pulse: letter accepted while full, oldest dropped
//  bad_code  out  1              1-cycle pulse: invalid code (29-31) captured
//  busy      out  1              FSM not in IDLE
// BEHAVIOUR
//  Reset: all digits blank, count=0, full=0, overflow=0, bad_code=0, FSM=IDLE,
//   key_rdy history register = 1 (a key held through reset is NOT captured).
//  FSM: IDLE -> CAPTURE on key_rdy sampled 1 with previous sample 0; key_code registered same edge.
//   CAPTURE -> HOLD unconditionally; buffer operation applied on this edge.
//   HOLD -> IDLE when key_rdy sampled 0. key_rdy stays high -> no repeats.
//  Latency: seg_out/count reflect the key two clk edges after key_rdy first sampled high.
//  Letter/space: digit[i] <= digit[i-1] for i>=1, digit[0] <= pattern; count+1 saturating
//   at NUM_DIGITS. If already full: shift still happens, top digit lost, overflow pulses.
//  Backspace: digit[i] <= digit[i+1], digit[NUM_DIGITS-1] <= blank, count-1.
//   If count==0: no change, no pulse.
//  Clear: all digits blank, count=0. Codes 29-31: buffer unchanged, bad_code pulses.
//  Pulses (overflow, bad_code) asserted only in the cycle after CAPTURE edge, else 0.
//  Patterns stored post-polarity; space stores blank. Standard DE1 letter approximations
//   (e.g. A = gfedcba 1110111, E = 1111001, H = 1110110). Active-low = bitwise inverse.
//  rst in any state: immediate return to reset values on that edge; in-flight key discarded.
//  key_rdy falling during CAPTURE: operation still applied, HOLD exits next cycle.
// CONFIGURATION
//  DISPLAY_BLINK_EN defined: free counter counts 0..BLINK_CYCLES-1.
//   Phase toggles at wrap. While full==1 and phase==1, every seg_out digit shows blank.
//   Stored contents unchanged. Counter and phase clear on reset and on every CAPTURE.
//  DISPLAY_BLINK_EN undefined: no counter; seg_out always equals stored digits.
// TESTING
//  1 rst, then key_rdy 0->1 with code 0 (A), hold 10 cycles -> digit0=7'h08 after 2 edges,
//    count=1, busy high until key_rdy low, no second capture.
//  2 type A,E,H -> digit2=7'h08, digit1=7'h06, digit0=7'h09, count=3.
//  3 NUM_DIGITS=6: 7 letters A..G -> full=1, overflow pulses once on 7th, digit5 holds B.
//  4 backspace after test 2 -> digit1=7'h08, digit0=7'h06, count=2.
//    Then clear -> all 7'h7F, count=0. Backspace on empty -> no change.
//  5 code 30 -> bad_code high one cycle, seg_out/count unchanged.
//    key_rdy held high across rst -> no capture until key_rdy 0->1.
//  6 DISPLAY_BLINK_EN, BLINK_CYCLES=4, buffer full -> seg_out alternates stored/all-7'h7F
//    every 4 cycles; non-full -> steady.

Source files
------------

// File: rtl/key_display_buffer.sv
// Scrolling N-digit 7-segment letter buffer fed by a PS2 key decoder (capture, backspace, clear).
// Optional build macro DISPLAY_BLINK_EN blinks the whole display while the buffer is full.
module key_display_buffer #(
    parameter int NUM_DIGITS     = 6,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
`ifdef DISPLAY_BLINK_EN
    parameter int BLINK_CYCLES   = 25000000,
`endif
    localparam int CW = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    key_rdy,
    input  logic [4:0]              key_code,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [CW-1:0]           count,
    output logic                    full,
    output logic                    overflow,
    output logic                    bad_code,
    output logic                    busy
);

    localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                         state;
    state_t                         next_state;
    logic                           key_prev;
    logic                           load_code;
    logic [4:0]                     code_reg;
    logic [NUM_DIGITS-1:0][6:0]     digits;

    // Letter approximations in gfedcba order, polarity applied on the way out; space is blank.
    function automatic logic [6:0] seg_pattern(input logic [4:0] code);
        logic [6:0] raw;
        case (code)
            5'd0:    raw = 7'h77;
            5'd1:    raw = 7'h7C;
            5'd2:    raw = 7'h39;
            5'd3:    raw = 7'h5E;
            5'd4:    raw = 7'h79;
            5'd5:    raw = 7'h71;
            5'd6:    raw = 7'h3D;
            5'd7:    raw = 7'h76;
            5'd8:    raw = 7'h06;
            5'd9:    raw = 7'h1E;
            5'd10:   raw = 7'h75;
            5'd11:   raw = 7'h38;
            5'd12:   raw = 7'h55;
            5'd13:   raw = 7'h37;
            5'd14:   raw = 7'h3F;
            5'd15:   raw = 7'h73;
            5'd16:   raw = 7'h67;
            5'd17:   raw = 7'h50;
            5'd18:   raw = 7'h6D;
            5'd19:   raw = 7'h78;
            5'd20:   raw = 7'h3E;
            5'd21:   raw = 7'h1C;
            5'd22:   raw = 7'h2A;
            5'd23:   raw = 7'h49;
            5'd24:   raw = 7'h6E;
            5'd25:   raw = 7'h5B;
            default: raw = 7'h00;
        endcase
        return SEG_ACTIVE_LOW ? ~raw : raw;
    endfunction

    // key_prev resets high so a key already held when reset lifts is not taken as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            key_prev <= 1'b1;
            code_reg <= '0;
        end else begin
            state    <= next_state;
            key_prev <= key_rdy;
            if (load_code) begin
                code_reg <= key_code;
            end
        end
    end

    always_comb begin
        next_state = state;
        load_code  = 1'b0;
        case (state)
            IDLE: begin
                if (key_rdy && !key_prev) begin
                    next_state = CAPTURE;
                    load_code  = 1'b1;
                end
            end
            CAPTURE: next_state = HOLD;
            HOLD: begin
                if (!key_rdy) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign full = (count == CW'(NUM_DIGITS));

    // Digit 0 is the newest letter; shifting left drops the oldest once the buffer is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits   <= {NUM_DIGITS{BLANK}};
            count    <= '0;
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
            if (state == CAPTURE) begin
                if (code_reg <= 5'd26) begin
                    digits <= {digits[NUM_DIGITS-2:0], seg_pattern(code_reg)};
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end else if (code_reg == 5'd27) begin
                    if (count != '0) begin
                        digits <= {BLANK, digits[NUM_DIGITS-1:1]};
                        count  <= count - CW'(1);
                    end
                end else if (code_reg == 5'd28) begin
                    digits <= {NUM_DIGITS{BLANK}};
                    count  <= '0;
                end else begin
                    bad_code <= 1'b1;
                end
            end
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    // Restarting on every capture keeps the blink aligned to the most recent key press.
    always_ff @(posedge clk) begin
        if (rst || state == CAPTURE) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + BW'(1);
        end
    end

    assign seg_out = (full && blink_phase) ? {NUM_DIGITS{BLANK}} : digits;
`else
    assign seg_out = digits;
`endif

endmodule
